shift_table_sequencer: RTL and testbench



---
 rtl/shift_tbl_pkg.sv | 21 ++
 rtl/shift_approx_unit.sv | 26 ++
 rtl/shift_table_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_shift_table_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_tbl_pkg.sv
// rtl/shift_tbl_pkg.sv - shared state encoding, shift-set record and default widths
package shift_tbl_pkg;

  localparam int FRAC_BITS_D = 8;
  localparam int SHW_D       = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [SHW_D-1:0] s0;
    logic [SHW_D-1:0] s1;
    logic [SHW_D-1:0] s2;
    logic [SHW_D-1:0] s3;
  } shift_set_t;

endpackage

// File: rtl/shift_approx_unit.sv
// rtl/shift_approx_unit.sv - maps one coefficient magnitude to a right-shift amount
module shift_approx_unit
  import shift_tbl_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_D,
  parameter int SHW       = SHW_D
) (
  input  logic [FRAC_BITS:0] coef,
  output logic [SHW-1:0]     shift
);

  // Scan from the largest candidate down so the smallest qualifying shift wins.
  always_comb begin
    shift = '0;
    if (coef == '0) begin
      shift = SHW'(FRAC_BITS);
    end else begin
      for (int i = SHW - 1; i >= 0; i--) begin
        if (i <= FRAC_BITS) begin
          if ((coef >> (FRAC_BITS - i)) != '0) shift = SHW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/shift_table_sequencer.sv
// rtl/shift_table_sequencer.sv - double-buffered shift table loader with atomic commit
// Optional clamp of every shift to MAX_SHIFT with clamp_hit output: SHIFT_TBL_CLAMP_EN
module shift_table_sequencer
  import shift_tbl_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_D,
  parameter int SHW       = SHW_D,
  parameter int NUM_SETS  = 16,
  parameter int IDXW      = $clog2(NUM_SETS)
`ifdef SHIFT_TBL_CLAMP_EN
  , parameter int MAX_SHIFT = FRAC_BITS
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FRAC_BITS:0]   in_c00,
  input  logic [FRAC_BITS:0]   in_c01,
  input  logic [FRAC_BITS:0]   in_c10,
  input  logic [FRAC_BITS:0]   in_c11,
  input  logic [IDXW-1:0]      rd_idx,
  output logic [SHW-1:0]       rd_s0,
  output logic [SHW-1:0]       rd_s1,
  output logic [SHW-1:0]       rd_s2,
  output logic [SHW-1:0]       rd_s3,
  output logic                 busy,
  output logic                 done,
  output logic                 table_valid,
  output logic                 bank_sel,
  output logic                 start_err
`ifdef SHIFT_TBL_CLAMP_EN
  , output logic               clamp_hit
`endif
);

  localparam int CW = IDXW + 1;

  typedef struct packed {
    logic [SHW-1:0] s0;
    logic [SHW-1:0] s1;
    logic [SHW-1:0] s2;
    logic [SHW-1:0] s3;
  } entry_t;

  seq_state_t       state;
  logic [CW-1:0]    count;
  logic [IDXW-1:0]  write_idx;
  logic             p_valid;
  entry_t           p_set;
  entry_t           p_next;
  entry_t           rd_set;
  entry_t           tbl [2][NUM_SETS];

  logic [FRAC_BITS:0] coef  [4];
  logic [SHW-1:0]     raw   [4];
  logic [SHW-1:0]     shv   [4];

  logic accept;
  logic abort_now;

  assign coef[0] = in_c00;
  assign coef[1] = in_c01;
  assign coef[2] = in_c10;
  assign coef[3] = in_c11;

  for (genvar g = 0; g < 4; g++) begin : g_approx
    shift_approx_unit #(
      .FRAC_BITS (FRAC_BITS),
      .SHW       (SHW)
    ) u_approx (
      .coef  (coef[g]),
      .shift (raw[g])
    );
  end

`ifdef SHIFT_TBL_CLAMP_EN
  logic [3:0] clamp_vec;
  logic       p_clamp;

  always_comb begin
    clamp_vec = '0;
    for (int g = 0; g < 4; g++) begin
      clamp_vec[g] = int'(raw[g]) > MAX_SHIFT;
      shv[g]       = clamp_vec[g] ? SHW'(MAX_SHIFT) : raw[g];
    end
  end

  assign clamp_hit = p_valid & p_clamp & ~abort_now;
`else
  always_comb begin
    for (int g = 0; g < 4; g++) shv[g] = raw[g];
  end
`endif

  assign p_next    = {shv[0], shv[1], shv[2], shv[3]};
  assign in_ready  = (state == LOAD) && (count < CW'(NUM_SETS));
  assign accept    = in_valid & in_ready;
  assign abort_now = abort && ((state == LOAD) || (state == DRAIN));
  assign busy      = (state != IDLE);

  always_comb begin
    rd_set = '0;
    if ({1'b0, rd_idx} < CW'(NUM_SETS)) rd_set = tbl[bank_sel][rd_idx];
  end

  assign rd_s0 = rd_set.s0;
  assign rd_s1 = rd_set.s1;
  assign rd_s2 = rd_set.s2;
  assign rd_s3 = rd_set.s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      write_idx   <= '0;
      p_valid     <= 1'b0;
      p_set       <= '0;
      bank_sel    <= 1'b0;
      table_valid <= 1'b0;
      done        <= 1'b0;
      start_err   <= 1'b0;
`ifdef SHIFT_TBL_CLAMP_EN
      p_clamp     <= 1'b0;
`endif
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_SETS; i++) tbl[b][i] <= '0;
      end
    end else begin
      done      <= 1'b0;
      start_err <= start && (state != IDLE);

      // P always lands in the shadow bank, i.e. the one readers are not using.
      if (p_valid && !abort_now) begin
        tbl[~bank_sel][write_idx] <= p_set;
        write_idx                 <= write_idx + IDXW'(1);
      end

      p_valid <= accept;
      if (accept) begin
        p_set <= p_next;
`ifdef SHIFT_TBL_CLAMP_EN
        p_clamp <= |clamp_vec;
`endif
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            count     <= '0;
            write_idx <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state     <= IDLE;
            count     <= '0;
            write_idx <= '0;
            p_valid   <= 1'b0;
          end else begin
            if (accept) count <= count + CW'(1);
            if (count == CW'(NUM_SETS)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            state     <= IDLE;
            count     <= '0;
            write_idx <= '0;
            p_valid   <= 1'b0;
          end else if (!p_valid) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          bank_sel    <= ~bank_sel;
          table_valid <= 1'b1;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_table_sequencer.sv
// tb/tb_shift_table_sequencer.sv - randomized bench for shift_table_sequencer against a table model
module tb_shift_table_sequencer;
  import shift_tbl_pkg::*;

  localparam int FB = FRAC_BITS_D;
  localparam int SW = SHW_D;
  localparam int NS = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, in_valid, in_ready;
  logic [FB:0]   in_c00, in_c01, in_c10, in_c11;
  logic [IW-1:0] rd_idx;
  logic [SW-1:0] rd_s0, rd_s1, rd_s2, rd_s3;
  logic          busy, done, table_valid, bank_sel, start_err;
`ifdef SHIFT_TBL_CLAMP_EN
  logic          clamp_hit;
`endif

  shift_table_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_c00      (in_c00),
    .in_c01      (in_c01),
    .in_c10      (in_c10),
    .in_c11      (in_c11),
    .rd_idx      (rd_idx),
    .rd_s0       (rd_s0),
    .rd_s1       (rd_s1),
    .rd_s2       (rd_s2),
    .rd_s3       (rd_s3),
    .busy        (busy),
    .done        (done),
    .table_valid (table_valid),
    .bank_sel    (bank_sel),
    .start_err   (start_err)
`ifdef SHIFT_TBL_CLAMP_EN
    , .clamp_hit (clamp_hit)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW-1:0] m_act [NS][4];
  logic [SW-1:0] m_new [NS][4];
  logic          m_bank;
  logic          m_tv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Shift = FB - floor(log2 v) when that fits below SW, else 0; zero maps to FB.
  function automatic int ref_shift(input int v);
    int m, t, r;
    if (v == 0) begin
      r = FB;
    end else begin
      m = 0;
      t = v;
      while (t > 1) begin
        t = t / 2;
        m++;
      end
      r = (FB - m < SW) ? FB - m : 0;
    end
`ifdef SHIFT_TBL_CLAMP_EN
    if (r > FB) r = FB;
`endif
    return r % (1 << SW);
  endfunction

  function automatic int pick_coef();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 1 << $urandom_range(0, FB);
      2:       return $urandom_range(0, (1 << (FB + 1)) - 1);
      default: return $urandom_range(0, 15);
    endcase
  endfunction

  task automatic check_read(input string tag, input int idx);
    rd_idx = IW'(idx);
    #1;
    check($sformatf("%s_s0_i%0d", tag, idx), rd_s0, m_act[idx][0]);
    check($sformatf("%s_s1_i%0d", tag, idx), rd_s1, m_act[idx][1]);
    check($sformatf("%s_s2_i%0d", tag, idx), rd_s2, m_act[idx][2]);
    check($sformatf("%s_s3_i%0d", tag, idx), rd_s3, m_act[idx][3]);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_bank_sel"}, bank_sel, m_bank);
    check({tag, "_table_valid"}, table_valid, m_tv);
  endtask

  // pattern: 0 = {256,128,100,0}, 1 = {511,5,8,16}, else random sets.
  task automatic do_load(input int pattern, input int gap_pct, input int abort_after,
                         input bit mid_start, input bit abort_with_start, input int poll_idx);
    int cv [NS][4];
    int pat0 [4] = '{256, 128, 100, 0};
    int pat1 [4] = '{511, 5, 8, 16};
    int acc, guard, ridx;
    bit exp_serr, mid_done;
    for (int k = 0; k < NS; k++) begin
      for (int j = 0; j < 4; j++) begin
        cv[k][j]    = (pattern == 0) ? pat0[j] : (pattern == 1) ? pat1[j] : pick_coef();
        m_new[k][j] = SW'(ref_shift(cv[k][j]));
      end
    end
    start = 1'b1;
    abort = abort_with_start;
    tick;
    start = 1'b0;
    abort = 1'b0;
    check("busy_after_start", busy, 1);
    acc = 0;
    guard = 0;
    exp_serr = 1'b0;
    mid_done = 1'b0;
    while (acc < NS && guard < 400) begin
      ridx = (poll_idx < 0) ? $urandom_range(0, NS - 1) : poll_idx;
      check("start_err", start_err, exp_serr);
      check("in_ready_load", in_ready, 1);
      check("done_load", done, 0);
      check_status("load");
      check_read("rd_old", ridx);
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_c00 = (FB+1)'(cv[acc][0]);
      in_c01 = (FB+1)'(cv[acc][1]);
      in_c10 = (FB+1)'(cv[acc][2]);
      in_c11 = (FB+1)'(cv[acc][3]);
      exp_serr = 1'b0;
      if (mid_start && acc == 5 && !mid_done) begin
        start = 1'b1;
        exp_serr = 1'b1;
        mid_done = 1'b1;
      end
      if (abort_after >= 0 && acc == abort_after) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        check("busy_after_abort", busy, 0);
        repeat (4) begin
          tick;
          check("done_after_abort", done, 0);
          check("in_ready_after_abort", in_ready, 0);
          check_status("abort");
          check_read("rd_after_abort", $urandom_range(0, NS - 1));
        end
        return;
      end
      tick;
      start = 1'b0;
      if (in_valid) acc++;
      guard++;
    end
    check("load_accept_count", acc, NS);
    in_valid = 1'b1;
    check("start_err_tail", start_err, exp_serr);
    check("in_ready_full", in_ready, 0);
    check_read("rd_old_full", (poll_idx < 0) ? 0 : poll_idx);
    tick;
    check("in_ready_drain", in_ready, 0);
    check("done_drain", done, 0);
    check("busy_drain", busy, 1);
    check_read("rd_old_drain", (poll_idx < 0) ? 1 : poll_idx);
    tick;
    check("in_ready_commit", in_ready, 0);
    check("done_commit", done, 0);
    check("busy_commit", busy, 1);
    check_read("rd_old_commit", (poll_idx < 0) ? 2 : poll_idx);
    tick;
    m_act  = m_new;
    m_bank = ~m_bank;
    m_tv   = 1'b1;
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("in_ready_done", in_ready, 0);
    check_status("done");
    check_read("rd_new", (poll_idx < 0) ? $urandom_range(0, NS - 1) : poll_idx);
    in_valid = 1'b0;
    tick;
    check("done_single", done, 0);
  endtask

  task automatic reset_model;
    for (int k = 0; k < NS; k++)
      for (int j = 0; j < 4; j++) m_act[k][j] = '0;
    m_bank = 1'b0;
    m_tv   = 1'b0;
  endtask

  initial begin
    int lit0 [4] = '{0, 1, 2, 8};
    int lit1 [4] = '{0, 0, 5, 4};
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_c00 = '0;
    in_c01 = '0;
    in_c10 = '0;
    in_c11 = '0;
    rd_idx = '0;
    reset_model();
    repeat (3) tick;
    rst_n = 1'b1;
    check_status("reset");
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_start_err", start_err, 0);
    check("reset_in_ready", in_ready, 0);
    for (int i = 0; i < NS; i += 5) check_read("rd_reset", i);
    in_valid = 1'b1;
    abort = 1'b1;
    #1;
    check("in_ready_idle", in_ready, 0);
    tick;
    in_valid = 1'b0;
    abort = 1'b0;
    check("busy_idle_abort", busy, 0);

    do_load(0, 0, -1, 1'b0, 1'b0, -1);
    check("bank_after_first", bank_sel, 1);
    for (int i = 0; i < NS; i++) begin
      rd_idx = IW'(i);
      #1;
      check("lit0_s0", rd_s0, lit0[0]);
      check("lit0_s1", rd_s1, lit0[1]);
      check("lit0_s2", rd_s2, lit0[2]);
      check("lit0_s3", rd_s3, lit0[3]);
    end

    do_load(1, 0, -1, 1'b0, 1'b0, -1);
    rd_idx = IW'(9);
    #1;
    check("lit1_s0", rd_s0, lit1[0]);
    check("lit1_s1", rd_s1, lit1[1]);
    check("lit1_s2", rd_s2, lit1[2]);
    check("lit1_s3", rd_s3, lit1[3]);

    do_load(2, 40, -1, 1'b0, 1'b0, 3);
    do_load(2, 10, 7, 1'b0, 1'b0, -1);
    do_load(2, 20, -1, 1'b0, 1'b0, -1);
    do_load(2, 0, -1, 1'b1, 1'b0, -1);
    check("bank_after_mid_start", bank_sel, m_bank);

    start = 1'b1;
    tick;
    start = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin
      in_c00 = (FB+1)'(pick_coef());
      in_c01 = (FB+1)'(pick_coef());
      in_c10 = (FB+1)'(pick_coef());
      in_c11 = (FB+1)'(pick_coef());
      tick;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    reset_model();
    check_status("midreset");
    check("midreset_busy", busy, 0);
    check("midreset_in_ready", in_ready, 0);
    for (int i = 0; i < NS; i += 3) check_read("rd_midreset", i);

    do_load(2, 30, -1, 1'b0, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
